// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage defaults and the next-PC select encoding.
package cpu_pkg;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;
  localparam int unsigned RAS_DEPTH    = 4;

  // Next-PC source, exported so waveforms show why the PC moved.
  typedef enum logic [2:0] {
    SEL_REDIRECT = 3'd0,
    SEL_HOLD     = 3'd1,
    SEL_JUMP     = 3'd2,
    SEL_RAS      = 3'd3,
    SEL_SEQ      = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between ID/EX control (master) and the PC unit (slave).
// All strobes are level requests sampled at the rising clock edge; there is no
// valid/ready backpressure, pc_write_i is the only stall qualifier.
interface pc_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 3
);

  logic              pc_write_i;
  logic              ex_redirect_i;
  logic [ADDR_W-1:0] ex_target_i;
  logic              id_jump_i;
  logic [ADDR_W-1:0] id_target_i;
  logic              ras_push_i;
  logic [ADDR_W-1:0] ras_push_data_i;
  logic              ras_pop_i;
  logic              ras_flush_i;
  logic [ADDR_W-1:0] pc_out_o;
  logic [ADDR_W-1:0] pc_plus_o;
  logic [CNT_W-1:0]  ras_count_o;
  logic              ras_underflow_o;
  pc_sel_e           pc_sel_o;

  modport master (
    output pc_write_i, ex_redirect_i, ex_target_i, id_jump_i, id_target_i,
           ras_push_i, ras_push_data_i, ras_pop_i, ras_flush_i,
    input  pc_out_o, pc_plus_o, ras_count_o, ras_underflow_o, pc_sel_o
  );

  modport slave (
    input  pc_write_i, ex_redirect_i, ex_target_i, id_jump_i, id_target_i,
           ras_push_i, ras_push_data_i, ras_pop_i, ras_flush_i,
    output pc_out_o, pc_plus_o, ras_count_o, ras_underflow_o, pc_sel_o
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. push/pop arrive already gated by the caller;
// flush wins over both and leaves entry contents untouched.
module pc_ras #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_dec;

  // ptr is the next free slot; DEPTH is a power of two so wrap is free.
  assign ptr_dec = ptr - 1'b1;
  assign top     = mem[ptr_dec];
  assign empty   = (count == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr_dec] <= push_data;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + 1'b1;
      if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority next-PC select over EX redirect,
// stall, ID jump, RAS prediction and sequential increment.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter int unsigned       INC       = PC_INC,
  parameter int unsigned       RAS_DEPTH = cpu_pkg::RAS_DEPTH,
  localparam int unsigned      CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic      clk_i,
  input  logic      rst_i,
  pc_unit_if.slave  bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_ok;
  logic              eff_push;
  logic              eff_pop;
  logic              underflow_q;
  pc_sel_e           sel;

  // A stalled or killed ID instruction is re-presented later, so it must
  // not touch the RAS now.
  assign ras_ok   = bus.pc_write_i && !bus.ex_redirect_i;
  assign eff_push = ras_ok && bus.ras_push_i;
  assign eff_pop  = ras_ok && bus.ras_pop_i && !bus.id_jump_i;

  always_comb begin
    sel = SEL_SEQ;
    if (bus.ex_redirect_i)                       sel = SEL_REDIRECT;
    else if (!bus.pc_write_i)                    sel = SEL_HOLD;
    else if (bus.id_jump_i)                      sel = SEL_JUMP;
    else if (bus.ras_pop_i && !ras_empty)        sel = SEL_RAS;
  end

  always_comb begin
    pc_next = bus.pc_plus_o;
    unique case (sel)
      SEL_REDIRECT: pc_next = bus.ex_target_i;
      SEL_HOLD:     pc_next = pc_q;
      SEL_JUMP:     pc_next = bus.id_target_i;
      SEL_RAS:      pc_next = ras_top;
      default:      pc_next = bus.pc_plus_o;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q        <= RESET_VEC;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_next;
      underflow_q <= eff_pop && ras_empty;
    end
  end

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH),
    .CNT_W  (CNT_W)
  ) u_ras (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (eff_push),
    .pop       (eff_pop),
    .flush     (bus.ras_flush_i),
    .push_data (bus.ras_push_data_i),
    .top       (ras_top),
    .count     (bus.ras_count_o),
    .empty     (ras_empty)
  );

  assign bus.pc_out_o        = pc_q;
  assign bus.pc_plus_o       = pc_q + ADDR_W'(INC);
  assign bus.ras_underflow_o = underflow_q;
  assign bus.pc_sel_o        = sel;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: driver queues hand-computed expectations,
// a monitor compares them one cycle later.
module tb_pc_unit;
  import cpu_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned EW     = 2 * ADDR_W + CNT_W + 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  pc_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pc_unit #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (32'h0000_3000),
    .INC       (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [EW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [EW-1:0] pack(logic [ADDR_W-1:0] pc, logic [CNT_W-1:0] cnt, logic uf);
    logic [ADDR_W-1:0] plus;
    plus = pc + 32'd4;
    return {pc, plus, cnt, uf};
  endfunction

  task automatic check(string name, logic [EW-1:0] got, logic [EW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got pc=%h plus=%h cnt=%0d uf=%b, expected pc=%h plus=%h cnt=%0d uf=%b",
               name, got[EW-1 -: ADDR_W], got[CNT_W+ADDR_W : CNT_W+1], got[CNT_W:1], got[0],
               exp[EW-1 -: ADDR_W], exp[CNT_W+ADDR_W : CNT_W+1], exp[CNT_W:1], exp[0]);
    end
  endtask

  // Drive one cycle of requests after the falling edge and queue the outcome.
  task automatic apply(logic pw, logic redir, logic [31:0] etgt, logic jump, logic [31:0] jtgt,
                       logic push, logic [31:0] pdata, logic pop, logic flush,
                       logic [31:0] exp_pc, logic [CNT_W-1:0] exp_cnt, logic exp_uf);
    @(negedge clk_i);
    bus.pc_write_i      = pw;
    bus.ex_redirect_i   = redir;
    bus.ex_target_i     = etgt;
    bus.id_jump_i       = jump;
    bus.id_target_i     = jtgt;
    bus.ras_push_i      = push;
    bus.ras_push_data_i = pdata;
    bus.ras_pop_i       = pop;
    bus.ras_flush_i     = flush;
    exp_q.push_back(pack(exp_pc, exp_cnt, exp_uf));
  endtask

  task automatic seq(logic [31:0] exp_pc, logic [CNT_W-1:0] exp_cnt, logic exp_uf);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, exp_pc, exp_cnt, exp_uf);
  endtask

  task automatic push(logic pw, logic [31:0] d, logic [31:0] exp_pc, logic [CNT_W-1:0] exp_cnt);
    apply(pw, 0, 0, 0, 0, 1, d, 0, 0, exp_pc, exp_cnt, 0);
  endtask

  task automatic pop(logic [31:0] exp_pc, logic [CNT_W-1:0] exp_cnt, logic exp_uf);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, exp_pc, exp_cnt, exp_uf);
  endtask

  // Monitor: one queued expectation per active edge, sampled 1 time unit later.
  always @(posedge clk_i) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {bus.pc_out_o, bus.pc_plus_o, bus.ras_count_o, bus.ras_underflow_o}, e);
    end
  end

  initial begin
    bus.pc_write_i = 0; bus.ex_redirect_i = 0; bus.ex_target_i = '0;
    bus.id_jump_i = 0; bus.id_target_i = '0; bus.ras_push_i = 0;
    bus.ras_push_data_i = '0; bus.ras_pop_i = 0; bus.ras_flush_i = 0;

    // Asynchronous reset, checked before the first rising edge.
    #2 rst_i = 1'b0;
    #1 check("async_reset", {bus.pc_out_o, bus.pc_plus_o, bus.ras_count_o, bus.ras_underflow_o},
             pack(32'h3000, 0, 0));
    @(negedge clk_i);
    rst_i = 1'b1;

    // Sequential after reset
    seq(32'h3004, 0, 0);
    seq(32'h3008, 0, 0);
    seq(32'h300C, 0, 0);
    // Stall, redirect overriding stall, jump ignored during stall
    apply(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0);
    apply(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0);
    apply(0, 0, 0, 1, 32'h200, 0, 0, 0, 0, 32'h100, 0, 0);
    apply(1, 0, 0, 1, 32'h200, 0, 0, 0, 0, 32'h200, 0, 0);
    // Fill past depth, then drain with one underflow
    push(1, 32'h10, 32'h204, 1);
    push(1, 32'h20, 32'h208, 2);
    push(1, 32'h30, 32'h20C, 3);
    push(1, 32'h40, 32'h210, 4);
    push(1, 32'h50, 32'h214, 4);
    pop(32'h50, 3, 0);
    pop(32'h40, 2, 0);
    pop(32'h30, 1, 0);
    pop(32'h20, 0, 0);
    pop(32'h24, 0, 1);
    seq(32'h28, 0, 0);
    // Simultaneous push/pop with a non-empty stack replaces the top
    push(1, 32'h80, 32'h2C, 1);
    apply(1, 0, 0, 0, 0, 1, 32'h90, 1, 0, 32'h80, 1, 0);
    pop(32'h90, 0, 0);
    // Simultaneous push/pop on empty: underflow for the PC, push still lands
    apply(1, 0, 0, 0, 0, 1, 32'hA0, 1, 0, 32'h94, 1, 1);
    pop(32'hA0, 0, 0);
    // Jump wins over pop and leaves the stack alone
    push(1, 32'hB0, 32'hA4, 1);
    apply(1, 0, 0, 1, 32'h300, 0, 0, 1, 0, 32'h300, 1, 0);
    pop(32'hB0, 0, 0);
    // Stalled pushes are dropped, the released one counts once
    push(0, 32'hC0, 32'hB0, 0);
    push(0, 32'hC0, 32'hB0, 0);
    push(0, 32'hC0, 32'hB0, 0);
    push(1, 32'hC0, 32'hB4, 1);
    apply(1, 1, 32'h400, 0, 0, 1, 32'hD0, 0, 0, 32'h400, 1, 0);
    // Flush beats a same-cycle push
    push(1, 32'hE0, 32'h404, 2);
    push(1, 32'hE4, 32'h408, 3);
    apply(1, 0, 0, 0, 0, 1, 32'hE8, 0, 1, 32'h40C, 0, 0);
    pop(32'h410, 0, 1);
    // Sequential wrap at the top of the address space
    apply(1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 0, 0);
    seq(32'hFFFF_FFFC, 0, 0);
    seq(32'h0000_0000, 0, 0);

    @(negedge clk_i);
    bus.pc_write_i = 0;
    repeat (3) @(posedge clk_i);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
